// File: rtl/int_source_ctrl.sv
// Interrupt request source: four debounced board inputs become queued requests
// on IR0-IR3, each held until the CPU has acknowledged every queued event.
module int_source_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       int_ack_valid,
  input  logic [1:0] int_ack_num,
  input  logic       ovf_clr,
  output logic [3:0] ir,
  output logic [7:0] pend_cnt,
  output logic [3:0] overflow
);

  localparam int SW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] STAB_LAST = SW'(DEBOUNCE_CYCLES - 1);

  for (genvar g = 0; g < 4; g++) begin : g_chan
    logic          s1, s2, lvl;
    logic [SW-1:0] stab, stab_nxt;
    logic [1:0]    cnt, cnt_nxt;
    logic          ovf, ovf_nxt;
    logic          flip, evt, ack;

    // stab never needs to hold DEBOUNCE_CYCLES itself: the level flips on the
    // edge where it would get there, so D-1 is the last stored value.
    assign flip = (s2 != lvl) && (stab == STAB_LAST);
    assign evt  = flip && s2;
    assign ack  = int_ack_valid && (int_ack_num == 2'(g)) && (cnt != 2'd0);

    always_comb begin
      stab_nxt = '0;
      cnt_nxt  = cnt;
      ovf_nxt  = ovf;
      if (s2 != lvl && !flip) stab_nxt = stab + 1'b1;
      if (ovf_clr) ovf_nxt = 1'b0;
      if (evt && !ack) begin
        if (cnt == 2'd3) ovf_nxt = 1'b1;
        else             cnt_nxt = cnt + 2'd1;
      end else if (ack && !evt) begin
        cnt_nxt = cnt - 2'd1;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1   <= 1'b0;
        s2   <= 1'b0;
        lvl  <= 1'b0;
        stab <= '0;
        cnt  <= 2'd0;
        ovf  <= 1'b0;
      end else begin
        s1   <= btn[g];
        s2   <= s1;
        stab <= stab_nxt;
        cnt  <= cnt_nxt;
        ovf  <= ovf_nxt;
        if (flip) lvl <= s2;
      end
    end

    assign ir[g]               = (cnt != 2'd0);
    assign pend_cnt[2*g+1:2*g] = cnt;
    assign overflow[g]         = ovf;
  end

endmodule

// File: tb/tb_int_source_ctrl.sv
// Directed bench for int_source_ctrl with D=4; expected values worked out by hand
// from the edge-by-edge debounce and queue behaviour.
module tb_int_source_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       int_ack_valid;
  logic [1:0] int_ack_num;
  logic       ovf_clr;
  logic [3:0] ir;
  logic [7:0] pend_cnt;
  logic [3:0] overflow;

  int n_checks = 0;
  int n_fail   = 0;

  int_source_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .int_ack_valid(int_ack_valid), .int_ack_num(int_ack_num),
    .ovf_clr(ovf_clr), .ir(ir), .pend_cnt(pend_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance n edges; returns 1 ns after the last one
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
  endtask

  task automatic press(input int ch);
    btn[ch] = 1'b1;
    tick(2 * D);
    btn[ch] = 1'b0;
    tick(2 * D);
  endtask

  task automatic ack_pulse(input logic [1:0] ch);
    int_ack_valid = 1'b1;
    int_ack_num   = ch;
    tick(1);
    int_ack_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    btn = 4'hF;
    int_ack_valid = 1'b0;
    int_ack_num = 2'd0;
    ovf_clr = 1'b0;

    // Reset with inputs high, then release: edge D+2 raises all lines
    tick(3);
    check_eq("rst_ir", ir, 4'h0);
    check_eq("rst_pend", pend_cnt, 8'h00);
    check_eq("rst_ovf", overflow, 4'h0);
    rst = 1'b1;
    tick(D + 1);
    check_eq("rel_ir_early", ir, 4'h0);
    tick(1);
    check_eq("rel_ir", ir, 4'hF);
    check_eq("rel_pend", pend_cnt, 8'h55);
    btn = 4'h0;
    tick(2 * D);
    do_reset();

    // Glitch of 3 cycles on channel 1
    btn[1] = 1'b1;
    tick(3);
    btn[1] = 1'b0;
    tick(2 * D);
    check_eq("glitch_ir", ir, 4'h0);
    check_eq("glitch_pend", pend_cnt, 8'h00);

    // Held 10 cycles: rises at edge k+5
    btn[1] = 1'b1;
    tick(5);
    check_eq("hold_ir_k4", ir, 4'h0);
    tick(1);
    check_eq("hold_ir_k5", ir, 4'h2);
    check_eq("hold_pend", pend_cnt, 8'h04);
    tick(4);
    btn[1] = 1'b0;
    tick(2 * D);
    check_eq("release_pend", pend_cnt, 8'h04);
    do_reset();

    // Queue and ack on channel 2
    press(2); press(2); press(2);
    check_eq("q3_pend", pend_cnt, 8'h30);
    ack_pulse(2'd2);
    check_eq("ack1_pend", pend_cnt, 8'h20);
    ack_pulse(2'd2);
    check_eq("ack2_pend", pend_cnt, 8'h10);
    check_eq("ack2_ir", ir, 4'h4);
    ack_pulse(2'd2);
    check_eq("ack3_pend", pend_cnt, 8'h00);
    check_eq("ack3_ir", ir, 4'h0);
    ack_pulse(2'd2);
    check_eq("ack4_pend", pend_cnt, 8'h00);
    check_eq("ack4_ovf", overflow, 4'h0);
    do_reset();

    // Overflow on channel 0
    press(0); press(0); press(0);
    check_eq("pre_ovf", overflow, 4'h0);
    press(0);
    check_eq("ovf_pend", pend_cnt, 8'h03);
    check_eq("ovf_set", overflow, 4'h1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check_eq("ovf_clr", overflow, 4'h0);
    check_eq("ovf_clr_pend", pend_cnt, 8'h03);
    btn[0] = 1'b1;
    tick(5);
    check_eq("ovf5_before", overflow, 4'h0);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check_eq("ovf_set_wins", overflow, 4'h1);
    tick(3);
    btn[0] = 1'b0;
    tick(2 * D);
    do_reset();

    // Event and ack together on channel 3 at cnt=3
    press(3); press(3); press(3);
    check_eq("ch3_full", pend_cnt, 8'hC0);
    btn[3] = 1'b1;
    tick(5);
    ack_pulse(2'd3);
    check_eq("evack3_pend", pend_cnt, 8'hC0);
    check_eq("evack3_ovf", overflow, 4'h0);
    tick(3);
    btn[3] = 1'b0;
    tick(2 * D);
    ack_pulse(2'd3); ack_pulse(2'd3); ack_pulse(2'd3);
    check_eq("ch3_drain", pend_cnt, 8'h00);

    // Event and ack together on channel 3 at cnt=0
    btn[3] = 1'b1;
    tick(5);
    ack_pulse(2'd3);
    check_eq("evack0_pend", pend_cnt, 8'h40);
    tick(3);
    btn[3] = 1'b0;
    tick(2 * D);

    // Ack to channel 1 (empty) while channel 0 gets an event
    btn[0] = 1'b1;
    tick(5);
    ack_pulse(2'd1);
    check_eq("cross_pend", pend_cnt, 8'h41);
    check_eq("cross_ir", ir, 4'h9);
    tick(3);
    btn[0] = 1'b0;
    tick(2 * D);
    do_reset();

    // Mid-operation reset with queue on ch2 and debounce running on ch0
    press(2); press(2);
    check_eq("mid_pre_pend", pend_cnt, 8'h20);
    btn[0] = 1'b1;
    tick(3);
    #2;
    rst = 1'b0;
    #1;
    check_eq("mid_ir", ir, 4'h0);
    check_eq("mid_pend", pend_cnt, 8'h00);
    check_eq("mid_ovf", overflow, 4'h0);
    #1;
    rst = 1'b1;
    tick(D + 1);
    check_eq("mid_no_early", ir, 4'h0);
    tick(1);
    check_eq("mid_fresh_ir", ir, 4'h1);
    check_eq("mid_fresh_pend", pend_cnt, 8'h01);
    btn[0] = 1'b0;
    tick(2 * D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_source_ctrl.md
# int_source_ctrl

Interrupt-request source for the four external interrupt lines IR0–IR3 consumed by the write-back stage's interrupt controller. It synchronises and debounces four raw board inputs and turns each debounced rising edge into a queued request. It holds the corresponding request line high until the CPU has acknowledged every queued request on that channel. It sits between the board I/O (buttons/peripheral strobes) and the CPU top level, driving the CPU's IR inputs and taking back an acknowledge when the CPU enters a handler.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised input must differ from its debounced level before the level flips (≥1; board builds override with a large value)
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- btn  in  4  raw asynchronous inputs; btn[n] feeds channel n
- int_ack_valid  in  1  one-cycle pulse: CPU has entered the handler for channel int_ack_num
- int_ack_num  in  2  channel index acknowledged (0–3)
- ovf_clr  in  1  clears all overflow flags
- ir  out  4  request lines to CPU IR0–IR3; ir[n] = (pend_cnt[n] != 0)
- pend_cnt  out  8  per-channel queued-request count, 2 bits per channel, channel n at [2n+1:2n]
- overflow  out  4  sticky; set when an event arrives on a channel whose count is already 3

## Operation
- Per channel: a 2-flop synchroniser (s1, s2), a debounced level `lvl`, a stability counter `stab` wide enough for DEBOUNCE_CYCLES, and a 2-bit pending count `cnt`.
- Debounce: if s2 == lvl, stab ← 0. Otherwise stab increments. At the edge where stab would reach DEBOUNCE_CYCLES, lvl ← s2 and stab ← 0.
- Event: asserted combinationally at the edge where lvl flips 0→1. A 1→0 flip produces no event.
- ack_n = int_ack_valid & (int_ack_num == n) & (cnt != 0). An acknowledge on a channel with cnt == 0 is ignored.
- Count update: cnt ← cnt + event − ack_n, with these cases:
  - event with cnt == 3 and no ack_n: cnt stays 3 and overflow[n] ← 1.
  - event and ack_n in the same cycle: cnt is unchanged, including at 3; no overflow.
  - event at cnt == 0 with an ack for the same channel: the ack is ignored and cnt → 1.
- Overflow: sticky until ovf_clr. If a set condition and ovf_clr coincide, set wins for that channel.
- Channels are fully independent. Acks to different channels never interact.

## Timing
- Reset (rst low, asynchronous) clears s1, s2, lvl, stab, cnt and overflow immediately, so ir = 0, pend_cnt = 0, overflow = 0.
- A reset asserted mid-debounce or with requests queued discards all of that state. No request is lost silently except by reset.
- An input held high across reset release is seen as a new rising edge. It raises ir D+2 cycles after release, where D = DEBOUNCE_CYCLES.
- Assert latency: btn[n] goes high and stays stable before sampling edge k.
  - s2 is high after edge k+1.
  - Mismatch is counted at edges k+2 … k+1+D.
  - lvl and cnt update at edge k+1+D; ir[n] is high after that edge.
  - Total: D+2 edges from the first sampling edge.
- A glitch shorter than D cycles (measured at s2) produces no event and leaves lvl unchanged.
- Release is debounced identically but produces no output change.
- Acknowledge: sampled at an edge; cnt decrements at that same edge. If cnt was 1, ir[n] falls after that edge (1-cycle response). int_ack_valid must be a single-cycle pulse per handler entry. If held high, it decrements once per cycle.
- ir, pend_cnt and overflow are pure functions of registers, with no combinational path from inputs.

## Test plan
- **Reset/idle:** rst=0 with btn=4'hF, then release. Require ir=0, pend_cnt=0, overflow=0 during reset. With D=4, ir=4'hF exactly 6 edges after release.
- **Debounce:**
  - D=4, pulse btn[1] high for 3 cycles: ir stays 0 and pend_cnt[3:2]=0.
  - Hold btn[1] high for 10 cycles: ir[1] rises at edge k+5 and pend_cnt[3:2]=1.
- **Queue and ack:**
  - Three clean presses on btn[2] (each ≥2D high, ≥2D low): pend_cnt[5:4]=3.
  - Ack channel 2 three times: counts 2, 1, 0. ir[2] drops after the third ack edge.
  - A fourth ack leaves the count at 0.
- **Overflow:**
  - Four presses on btn[0] with no ack: pend_cnt[1:0]=3 and overflow=4'b0001.
  - ovf_clr pulse: overflow=0 and the count stays 3.
  - ovf_clr coincident with a fifth event: overflow stays 1.
- **Simultaneous events:**
  - Event and ack on channel 3 in the same cycle with cnt=3: cnt=3 and overflow[3]=0.
  - Same with cnt=0: cnt=1.
  - Ack for channel 1 while channel 0 gets an event: only channel 0's count changes.
- **Mid-operation reset:** with cnt=2 on channel 2 and a debounce in progress on channel 0, pulse rst low between edges. Require outputs to clear before the next edge and no event to occur without a fresh D-cycle stable input.
